// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared opcodes, bubble encoding and fetch state for the 16-bit pipeline
package fetch_stage_pkg;

  localparam logic [4:0] OP_HALT = 5'b00000;
  localparam logic [4:0] OP_NOP  = 5'b00001;
  localparam logic [4:0] OP_BEQZ = 5'b01000;
  localparam logic [4:0] OP_BNEZ = 5'b01001;
  localparam logic [4:0] OP_BLTZ = 5'b01010;
  localparam logic [4:0] OP_BGEZ = 5'b01011;
  localparam logic [4:0] OP_J    = 5'b01100;
  localparam logic [4:0] OP_JR   = 5'b01101;
  localparam logic [4:0] OP_JAL  = 5'b01110;
  localparam logic [4:0] OP_JALR = 5'b01111;

  localparam logic [15:0] NOP_INSTR = 16'h0800;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc2;
    logic        valid;
  } if_id_t;

  function automatic logic is_halt(input logic [15:0] instr);
    return instr[15:11] == OP_HALT;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register; flush loads a bubble, hold keeps contents
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [15:0] NOP = NOP_INSTR
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   hold,
  input  logic   flush,
  input  if_id_t d,
  output if_id_t q
);

  localparam if_id_t BUBBLE = '{instr: NOP, pc2: 16'h0000, valid: 1'b0};

  // flush outranks hold so a squash never gets stuck behind a stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= BUBBLE;
    end else if (flush) begin
      q <= BUBBLE;
    end else if (!hold) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC, fetch FSM, redirect/bubble injection and bubble counter
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  output logic [15:0]      imem_addr,
  input  logic [15:0]      imem_data,
  input  logic             imem_stall,
  input  logic             control_hazard,
  input  logic             stall_decode,
  input  logic             redirect_valid,
  input  logic [15:0]      redirect_target,
  output logic [15:0]      instr_decode,
  output logic [15:0]      pc2_decode,
  output logic             valid_decode,
  output logic             halted,
  output logic [CNT_W-1:0] bubble_count
);

  fetch_state_t state, next_state;
  logic [15:0]  pc, pc_next, pc_plus2;
  logic         flush, hold;
  if_id_t       if_id_d, if_id_q;

  assign pc_plus2  = pc + 16'd2;
  assign imem_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_RUN;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (redirect_valid) begin
      next_state = ST_RUN;
    end else if (state == ST_RUN && !stall_decode && !control_hazard &&
                 !imem_stall && is_halt(imem_data)) begin
      next_state = ST_HALTED;
    end
  end

  // priority: redirect > stall_decode > control_hazard > imem_stall > fetch
  always_comb begin
    pc_next = pc;
    flush   = 1'b0;
    hold    = 1'b0;
    halted  = (state == ST_HALTED);
    if (redirect_valid) begin
      pc_next = redirect_target & 16'hFFFE;
      flush   = 1'b1;
    end else if (stall_decode) begin
      hold = 1'b1;
    end else if (state == ST_HALTED || control_hazard || imem_stall) begin
      flush = 1'b1;
    end else if (!is_halt(imem_data)) begin
      pc_next = pc_plus2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc <= RESET_PC;
    else     pc <= pc_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_count <= '0;
    end else if (flush && bubble_count != {CNT_W{1'b1}}) begin
      bubble_count <= bubble_count + 1'b1;
    end
  end

  assign if_id_d = '{instr: imem_data, pc2: pc_plus2, valid: 1'b1};

  if_id_reg #(.NOP(NOP_INSTR)) u_if_id (
    .clk   (clk),
    .rst   (rst),
    .hold  (hold),
    .flush (flush),
    .d     (if_id_d),
    .q     (if_id_q)
  );

  assign instr_decode = if_id_q.instr;
  assign pc2_decode   = if_id_q.pc2;
  assign valid_decode = if_id_q.valid;

endmodule
